// File: rtl/ttt_pkg.sv
// Shared definitions for the Tic Tac Toe game controller and text painter.
package ttt_pkg;

  // Two-bit cell encodings used on the board bus
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  // Game controller states
  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Winning lines as cell-index triples, 4 bits per index, line 0 in the LSBs.
  // Order: rows 0..2, columns 0..2, main diagonal, anti-diagonal.
  localparam logic [NUM_LINES*3*4-1:0] LINE_TABLE = {
    4'd6, 4'd4, 4'd2,   // line 7: anti-diagonal
    4'd8, 4'd4, 4'd0,   // line 6: main diagonal
    4'd8, 4'd5, 4'd2,   // line 5: column 2
    4'd7, 4'd4, 4'd1,   // line 4: column 1
    4'd6, 4'd3, 4'd0,   // line 3: column 0
    4'd8, 4'd7, 4'd6,   // line 2: row 2
    4'd5, 4'd4, 4'd3,   // line 1: row 1
    4'd2, 4'd1, 4'd0    // line 0: row 0
  };

  // Cell index of position pos (0..2) within line number line (0..7)
  function automatic int line_cell(input int line, input int pos);
    return int'(LINE_TABLE[(line*3 + pos)*4 +: 4]);
  endfunction

  // 12-bit RGB colours shared with the painter
  localparam logic [11:0] RGB_BACKGROUND = 12'h000;
  localparam logic [11:0] RGB_GRID       = 12'hFFF;
  localparam logic [11:0] RGB_MARK_X     = 12'hF00;
  localparam logic [11:0] RGB_MARK_O     = 12'h00F;
  localparam logic [11:0] RGB_CURSOR     = 12'hFF0;
  localparam logic [11:0] RGB_TEXT       = 12'h0F0;

endpackage

// File: rtl/ttt_line_check.sv
// Combinational board evaluator: reports a three-in-a-row winner and whether
// every cell is occupied.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  output logic [1:0]  winner,
  output logic        full
);

  logic [NUM_LINES-1:0] x_line;
  logic [NUM_LINES-1:0] o_line;
  logic [NUM_CELLS-1:0] occupied;

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      localparam int C0 = line_cell(gi, 0);
      localparam int C1 = line_cell(gi, 1);
      localparam int C2 = line_cell(gi, 2);
      assign x_line[gi] = (board[2*C0 +: 2] == CELL_X) &&
                          (board[2*C1 +: 2] == CELL_X) &&
                          (board[2*C2 +: 2] == CELL_X);
      assign o_line[gi] = (board[2*C0 +: 2] == CELL_O) &&
                          (board[2*C1 +: 2] == CELL_O) &&
                          (board[2*C2 +: 2] == CELL_O);
    end

    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
      assign occupied[gi] = (board[2*gi +: 2] != CELL_EMPTY);
    end
  endgenerate

  // Only the player who just moved can complete a line, so X/O priority is moot
  always_comb begin
    winner = CELL_EMPTY;
    if (|x_line) begin
      winner = CELL_X;
    end else if (|o_line) begin
      winner = CELL_O;
    end
  end

  assign full = &occupied;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic Tac Toe game-state controller: turns left/right/select buttons into the
// registered board, cursor, turn, result, menu and score values for the painter.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int SCORE_MAX = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic [17:0] board,
  output logic [3:0]  cursor,
  output logic        turn,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        menu_sel,
  output logic [3:0]  score_x,
  output logic [3:0]  score_o
);

  localparam logic [3:0] CURSOR_HOME = 4'd4;
  localparam logic [3:0] CURSOR_LAST = 4'd8;
  localparam logic [3:0] SCORE_CAP   = 4'(SCORE_MAX);

  // Button front end: bit 0 = left, bit 1 = right, bit 2 = select
  logic [2:0] btn_raw;
  logic [2:0] pulse;

  assign btn_raw = {btn_sel, btn_right, btn_left};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic s1_reg;
      logic s2_reg;
      logic s3_reg;

      // Two-stage synchronizer plus a delay stage for rising-edge detection
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
          s3_reg <= 1'b0;
        end else begin
          s1_reg <= btn_raw[gi];
          s2_reg <= s1_reg;
          s3_reg <= s2_reg;
        end
      end

      assign pulse[gi] = s2_reg & ~s3_reg;
    end
  endgenerate

  // Coincident presses are ambiguous, so only a lone pulse is honoured
  logic left_p;
  logic right_p;
  logic sel_p;

  assign left_p  = (pulse == 3'b001);
  assign right_p = (pulse == 3'b010);
  assign sel_p   = (pulse == 3'b100);

  // Game state registers
  state_t      state_reg,     state_next;
  logic [17:0] board_reg,     board_next;
  logic [3:0]  cursor_reg,    cursor_next;
  logic        turn_reg,      turn_next;
  logic        game_over_reg, game_over_next;
  logic [1:0]  winner_reg,    winner_next;
  logic        menu_sel_reg,  menu_sel_next;
  logic [3:0]  score_x_reg,   score_x_next;
  logic [3:0]  score_o_reg,   score_o_next;

  logic [1:0]  line_winner;
  logic        board_full;
  logic [1:0]  cursor_cell;

  ttt_line_check u_line_check (
    .board  (board_reg),
    .winner (line_winner),
    .full   (board_full)
  );

  assign cursor_cell = board_reg[2*cursor_reg +: 2];

  // State and datapath registers; reset aborts any game in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= PLAY;
      board_reg     <= '0;
      cursor_reg    <= CURSOR_HOME;
      turn_reg      <= 1'b0;
      game_over_reg <= 1'b0;
      winner_reg    <= CELL_EMPTY;
      menu_sel_reg  <= 1'b0;
      score_x_reg   <= '0;
      score_o_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      board_reg     <= board_next;
      cursor_reg    <= cursor_next;
      turn_reg      <= turn_next;
      game_over_reg <= game_over_next;
      winner_reg    <= winner_next;
      menu_sel_reg  <= menu_sel_next;
      score_x_reg   <= score_x_next;
      score_o_reg   <= score_o_next;
    end
  end

  // Next-state and datapath updates for PLAY / CHECK / OVER
  always_comb begin
    state_next     = state_reg;
    board_next     = board_reg;
    cursor_next    = cursor_reg;
    turn_next      = turn_reg;
    game_over_next = game_over_reg;
    winner_next    = winner_reg;
    menu_sel_next  = menu_sel_reg;
    score_x_next   = score_x_reg;
    score_o_next   = score_o_reg;

    case (state_reg)
      PLAY: begin
        if (left_p) begin
          cursor_next = (cursor_reg == 4'd0) ? CURSOR_LAST : cursor_reg - 4'd1;
        end else if (right_p) begin
          cursor_next = (cursor_reg == CURSOR_LAST) ? 4'd0 : cursor_reg + 4'd1;
        end else if (sel_p && (cursor_cell == CELL_EMPTY)) begin
          board_next[2*cursor_reg +: 2] = turn_reg ? CELL_O : CELL_X;
          state_next = CHECK;
        end
      end

      // Pulses are ignored here; the board is judged on the just-placed mark
      CHECK: begin
        if (line_winner != CELL_EMPTY) begin
          winner_next    = line_winner;
          game_over_next = 1'b1;
          state_next     = OVER;
          if (line_winner == CELL_X) begin
            if (score_x_reg < SCORE_CAP) score_x_next = score_x_reg + 4'd1;
          end else begin
            if (score_o_reg < SCORE_CAP) score_o_next = score_o_reg + 4'd1;
          end
        end else if (board_full) begin
          winner_next    = CELL_EMPTY;
          game_over_next = 1'b1;
          state_next     = OVER;
        end else begin
          turn_next  = ~turn_reg;
          state_next = PLAY;
        end
      end

      OVER: begin
        if (left_p || right_p) begin
          menu_sel_next = ~menu_sel_reg;
        end else if (sel_p) begin
          board_next     = '0;
          cursor_next    = CURSOR_HOME;
          turn_next      = 1'b0;
          winner_next    = CELL_EMPTY;
          game_over_next = 1'b0;
          state_next     = PLAY;
          if (menu_sel_reg) begin
            score_x_next = '0;
            score_o_next = '0;
          end
        end
      end

      default: begin
        state_next = PLAY;
      end
    endcase
  end

  assign board     = board_reg;
  assign cursor    = cursor_reg;
  assign turn      = turn_reg;
  assign game_over = game_over_reg;
  assign winner    = winner_reg;
  assign menu_sel  = menu_sel_reg;
  assign score_x   = score_x_reg;
  assign score_o   = score_o_reg;

endmodule
